// File: rtl/ysyx_23060187_multicycle_core_if.sv
// ysyx_23060187_multicycle_core_if: instruction fetch request/response bus
interface ysyx_23060187_multicycle_core_if;
  logic        ifu_req_valid;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rdata;
  modport master (output ifu_req_valid, ifu_addr, input ifu_rsp_valid, ifu_rdata);
  modport slave  (input ifu_req_valid, ifu_addr, output ifu_rsp_valid, ifu_rdata);
endinterface

// File: rtl/ysyx_23060187_multicycle_core.sv
// ysyx_23060187_multicycle_core: two-cycle fetch/execute RV32I subset core with sticky halt
module ysyx_23060187_multicycle_core #(
  parameter int          NR_REGS  = 32,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  ysyx_23060187_multicycle_core_if.master       ifu,
  output logic [31:0]                           pc,
  output logic                                  retire,
  output logic                                  halt,
  output logic                                  illegal,
  input  logic [4:0]                            dbg_raddr,
  output logic [31:0]                           dbg_rdata
);
  localparam logic [5:0] NR = 6'(NR_REGS);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d;
  logic        ill_q, ill_d, we;
  logic [31:0] rf_q [32];
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_u, imm_j, rs1_v, rs2_v, jal_t, jalr_t, wd, npc;
  logic        lui, auipc, jal, jalr, addi, add, sub, ebreak, idx_bad, bad;
  assign op    = ir_q[6:0];
  assign rd    = ir_q[11:7];
  assign rs1   = ir_q[19:15];
  assign rs2   = ir_q[24:20];
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  // Entries at or above NR_REGS are never written and always read as zero
  assign rs1_v = (rs1 != 5'd0 && {1'b0, rs1} < NR) ? rf_q[rs1] : 32'd0;
  assign rs2_v = (rs2 != 5'd0 && {1'b0, rs2} < NR) ? rf_q[rs2] : 32'd0;
  assign dbg_rdata = (dbg_raddr != 5'd0 && {1'b0, dbg_raddr} < NR) ? rf_q[dbg_raddr] : 32'd0;
  assign lui    = op == 7'b0110111;
  assign auipc  = op == 7'b0010111;
  assign jal    = op == 7'b1101111;
  assign jalr   = op == 7'b1100111 && ir_q[14:12] == 3'b000;
  assign addi   = op == 7'b0010011 && ir_q[14:12] == 3'b000;
  assign add    = op == 7'b0110011 && ir_q[14:12] == 3'b000 && ir_q[31:25] == 7'h00;
  assign sub    = op == 7'b0110011 && ir_q[14:12] == 3'b000 && ir_q[31:25] == 7'h20;
  assign ebreak = ir_q == 32'h0010_0073;
  assign jal_t  = pc_q + imm_j;
  assign jalr_t = (rs1_v + imm_i) & ~32'd1;
  assign idx_bad = ({1'b0, rd} >= NR && (lui | auipc | jal | jalr | addi | add | sub))
                || ({1'b0, rs1} >= NR && (jalr | addi | add | sub))
                || ({1'b0, rs2} >= NR && (add | sub));
  assign bad = !(lui | auipc | jal | jalr | addi | add | sub | ebreak) || idx_bad
            || (jal && jal_t[1]) || (jalr && jalr_t[1]);
  assign wd  = lui ? imm_u : auipc ? pc_q + imm_u : (jal | jalr) ? pc_q + 32'd4 :
               addi ? rs1_v + imm_i : add ? rs1_v + rs2_v : rs1_v - rs2_v;
  assign npc = jal ? jal_t : jalr ? jalr_t : pc_q + 32'd4;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ill_d   = ill_q;
    we      = 1'b0;
    if (state_q == FETCH && ifu.ifu_rsp_valid) begin
      ir_d    = ifu.ifu_rdata;
      state_d = EXEC;
    end else if (state_q == EXEC) begin
      if (bad) begin
        ill_d   = 1'b1;
        state_d = HALT;
      end else if (ebreak) begin
        state_d = HALT;
      end else begin
        pc_d    = npc;
        we      = rd != 5'd0;
        state_d = FETCH;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ill_q   <= ill_d;
    end
  end
  // Register file is deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) rf_q[rd] <= wd;
  end
  assign ifu.ifu_req_valid = state_q == FETCH;
  assign ifu.ifu_addr      = pc_q;
  assign pc      = pc_q;
  assign retire  = state_q == EXEC && !bad;
  assign halt    = state_q == HALT;
  assign illegal = ill_q;
endmodule

// File: tb/tb_ysyx_23060187_multicycle_core.sv
// tb_ysyx_23060187_multicycle_core: directed table plus corner sequences for the multicycle core
module tb_ysyx_23060187_multicycle_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc, pc2, dbg_rdata, dbg_rdata2;
  logic        retire, halt, illegal, retire2, halt2, illegal2;
  logic [4:0]  dbg_raddr = 5'd0, dbg_raddr2 = 5'd0;
  int          n_chk = 0, n_bad = 0;
  ysyx_23060187_multicycle_core_if bus();
  ysyx_23060187_multicycle_core_if bus2();
  ysyx_23060187_multicycle_core dut (
    .clk(clk), .rst(rst), .ifu(bus), .pc(pc), .retire(retire), .halt(halt),
    .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata));
  ysyx_23060187_multicycle_core #(.NR_REGS(16)) dut16 (
    .clk(clk), .rst(rst), .ifu(bus2), .pc(pc2), .retire(retire2), .halt(halt2),
    .illegal(illegal2), .dbg_raddr(dbg_raddr2), .dbg_rdata(dbg_rdata2));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] npc;
  } vec_t;
  vec_t tv [9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rd_reg(input logic [4:0] r, input string name, input logic [31:0] exp);
    dbg_raddr = r;
    #1;
    chk(name, dbg_rdata, exp);
  endtask
  task automatic feed(input logic [31:0] w, input logic exp_ret);
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rdata     = w;
    step();
    bus.ifu_rsp_valid = 1'b0;
    chk("exec_retire", {31'd0, retire}, {31'd0, exp_ret});
    step();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask
  initial begin
    logic [31:0] exp_pc;
    tv[0] = '{32'h0050_0093, 5'd1, 32'h0000_0005, 32'h8000_0004};
    tv[1] = '{32'hFF90_8113, 5'd2, 32'hFFFF_FFFE, 32'h8000_0008};
    tv[2] = '{32'h4020_81B3, 5'd3, 32'h0000_0007, 32'h8000_000C};
    tv[3] = '{32'h0020_8233, 5'd4, 32'h0000_0003, 32'h8000_0010};
    tv[4] = '{32'h1234_52B7, 5'd5, 32'h1234_5000, 32'h8000_0014};
    tv[5] = '{32'h0000_1317, 5'd6, 32'h8000_1014, 32'h8000_0018};
    tv[6] = '{32'h0010_8013, 5'd0, 32'h0000_0000, 32'h8000_001C};
    tv[7] = '{32'h0100_00EF, 5'd1, 32'h8000_0020, 32'h8000_002C};
    tv[8] = '{32'h0000_80E7, 5'd1, 32'h8000_0030, 32'h8000_0020};
    bus.ifu_rsp_valid  = 1'b0;
    bus.ifu_rdata      = 32'd0;
    bus2.ifu_rsp_valid = 1'b0;
    bus2.ifu_rdata     = 32'd0;
    #12;
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_flags", {29'd0, retire, halt, illegal}, 32'd0);
    chk("rst_req", {31'd0, bus.ifu_req_valid}, 32'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_req", {31'd0, bus.ifu_req_valid}, 32'd1);
      chk("idle_addr", bus.ifu_addr, 32'h8000_0000);
      chk("idle_retire", {31'd0, retire}, 32'd0);
    end
    exp_pc = 32'h8000_0000;
    for (int i = 0; i < 9; i++) begin
      chk("vec_req", {31'd0, bus.ifu_req_valid}, 32'd1);
      chk("vec_addr", bus.ifu_addr, exp_pc);
      feed(tv[i].instr, 1'b1);
      rd_reg(tv[i].rd, "vec_rd", tv[i].val);
      chk("vec_pc", pc, tv[i].npc);
      exp_pc = tv[i].npc;
    end
    do_reset();
    feed(32'h0100_00EF, 1'b1);
    rd_reg(5'd1, "jal_x1", 32'h8000_0004);
    chk("jal_addr", bus.ifu_addr, 32'h8000_0010);
    feed(32'h0000_80E7, 1'b1);
    rd_reg(5'd1, "jalr_x1", 32'h8000_0014);
    chk("jalr_addr", bus.ifu_addr, 32'h8000_0004);
    feed(32'h0020_8167, 1'b0);
    chk("mis_flags", {29'd0, retire, halt, illegal}, 32'd3);
    chk("mis_pc", pc, 32'h8000_0004);
    chk("mis_req", {31'd0, bus.ifu_req_valid}, 32'd0);
    rd_reg(5'd2, "mis_x2", 32'hFFFF_FFFE);
    do_reset();
    feed(32'h0010_0073, 1'b1);
    chk("ebk_flags", {29'd0, retire, halt, illegal}, 32'd2);
    chk("ebk_pc", pc, 32'h8000_0000);
    for (int i = 0; i < 3; i++) begin
      bus.ifu_rsp_valid = 1'b1;
      bus.ifu_rdata     = 32'h0050_0093;
      step();
      bus.ifu_rsp_valid = 1'b0;
      chk("ebk_hold", {29'd0, retire, halt, illegal, bus.ifu_req_valid}, 32'd4);
      chk("ebk_pc_hold", pc, 32'h8000_0000);
    end
    rd_reg(5'd1, "ebk_x1", 32'h8000_0014);
    do_reset();
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rdata     = 32'h0090_0293;
    step();
    bus.ifu_rsp_valid = 1'b0;
    chk("ar_exec_retire", {31'd0, retire}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("ar_retire", {31'd0, retire}, 32'd0);
    chk("ar_req", {31'd0, bus.ifu_req_valid}, 32'd1);
    chk("ar_pc", pc, 32'h8000_0000);
    step();
    rst = 1'b0;
    step();
    rd_reg(5'd5, "ar_x5", 32'h1234_5000);
    chk("ar_addr", bus.ifu_addr, 32'h8000_0000);
    chk("ar_req2", {31'd0, bus.ifu_req_valid}, 32'd1);
    bus2.ifu_rsp_valid = 1'b1;
    bus2.ifu_rdata     = 32'h0010_0A13;
    step();
    bus2.ifu_rsp_valid = 1'b0;
    chk("r16_retire", {31'd0, retire2}, 32'd0);
    step();
    chk("r16_flags", {29'd0, retire2, halt2, illegal2}, 32'd3);
    chk("r16_req", {31'd0, bus2.ifu_req_valid}, 32'd0);
    chk("r16_pc", pc2, 32'h8000_0000);
    dbg_raddr2 = 5'd20;
    #1;
    chk("r16_x20", dbg_rdata2, 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_23060187_multicycle_core.md
YSYX_23060187_MULTICYCLE_CORE -- requirements
Module: ysyx_23060187_multicycle_core

Interface
REQ-001 SHALL have parameter NR_REGS, default 32, number of integer registers; legal values 16 (RV32E) or 32.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port ifu_req_valid  output  1  fetch request pending.
REQ-006 SHALL have port ifu_addr  output  32  fetch address; equals pc.
REQ-007 SHALL have port ifu_rsp_valid  input  1  instruction word valid this cycle.
REQ-008 SHALL have port ifu_rdata  input  32  instruction word.
REQ-009 SHALL have port pc  output  32  architectural PC of the instruction being fetched or executed.
REQ-010 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-011 SHALL have port halt  output  1  core stopped; sticky until reset.
REQ-012 SHALL have port illegal  output  1  halt was caused by an illegal or unsupported instruction; sticky.
REQ-013 SHALL have port dbg_raddr  input  5  debug register index.
REQ-014 SHALL have port dbg_rdata  output  32  combinational register value; 0 for index 0 or index >= NR_REGS.

Function
REQ-015 SHALL implement the FSM states FETCH, EXEC and HALT.
REQ-016 FETCH: ifu_req_valid=1 and ifu_addr=pc; when ifu_rsp_valid=1, latch ifu_rdata into the IR and go to EXEC next cycle; otherwise stay in FETCH with no timeout.
REQ-017 EXEC: lasts exactly one cycle; write rd, update pc, assert retire, then return to FETCH. ifu_req_valid=0.
REQ-018 ifu_rsp_valid SHALL be ignored in EXEC and HALT.
REQ-019 Supported instructions: LUI, AUIPC, JAL, JALR (funct3=000), ADDI, ADD (funct7=0), SUB (funct7=0x20), EBREAK (32'h0010_0073).
REQ-020 Results: LUI rd=imm_u; AUIPC rd=pc+imm_u; JAL/JALR rd=pc+4; ADDI rd=rs1+sext(imm_i); ADD/SUB rd=rs1±rs2; all arithmetic is modulo 2^32.
REQ-021 Next pc: JAL pc+sext(imm_j); JALR (rs1+sext(imm_i)) & ~1; all others pc+4, wrapping at 2^32.
REQ-022 The write to x0 SHALL be discarded; x0 reads as 0.
REQ-023 JALR SHALL use the rs1 value from before its own writeback when rd==rs1.
REQ-024 Illegal cases go to HALT with illegal=1, no register write, pc unchanged, and no retire: any other opcode or funct, or any rd/rs1/rs2 index >= NR_REGS, or a jump target with bit 1 set.
REQ-025 EBREAK: go to HALT with halt=1 and illegal=0; retire pulses once; pc is unchanged.
REQ-026 HALT: absorbing state; ifu_req_valid=0, retire=0, and registers frozen; only reset exits.
REQ-027 At most one retire per two cycles; minimum latency from rsp accept to retire is 1 cycle.

Reset
REQ-028 While rst=1, immediately and regardless of clk: state=FETCH, pc=RESET_PC, retire=0, halt=0, illegal=0, IR=0.
REQ-029 Register file contents are not reset; only x0 is guaranteed to read 0.
REQ-030 Reset during EXEC SHALL abort the instruction with no register write; after release, the first request is at RESET_PC in the first cycle.

Verification
REQ-031 Reset release, rsp held low for 5 cycles -> ifu_req_valid=1 and ifu_addr=32'h8000_0000 throughout; retire stays 0.
REQ-032 Feed ADDI x1,x0,5, then ADDI x2,x1,-7, then SUB x3,x1,x2 -> dbg x1=5, x2=32'hFFFF_FFFE, x3=7; three retire pulses; pc ends at 32'h8000_000C.
REQ-033 Feed JAL x1,+16 at 32'h8000_0000, then JALR x1,0(x1) -> x1=32'h8000_0004 then 32'h8000_0014; next fetch addresses are 32'h8000_0010 and then 32'h8000_0004.
REQ-034 Instantiate with NR_REGS=16 and feed ADDI x20,x0,1 -> halt=1, illegal=1, retire=0, and no further requests.
REQ-035 Feed EBREAK -> one retire pulse, then halt=1 and illegal=0; pc holds; later ifu_rsp_valid pulses are ignored.
REQ-036 Assert rst asynchronously mid-EXEC of ADDI x5,x0,9 -> outputs clear before the next edge; x5 is unchanged and fetch restarts at RESET_PC.
